// File: rtl/clock_rate_controller.sv
// Divided-clock generator with four runtime-selectable rates; rate/stop changes apply only at the 1->0 boundary.
// Registered outputs, one-cycle response to controls; no backpressure (tick is a free-running strobe).
module clock_rate_controller #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int RATE0_FREQUENCY = 1,
  parameter int RATE1_FREQUENCY = 2,
  parameter int RATE2_FREQUENCY = 5,
  parameter int RATE3_FREQUENCY = 10,
  parameter int DEFAULT_RATE    = 0,
  parameter int CNT_WIDTH       = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  input  logic       rate_load,
  output logic       divided_clk,
  output logic       tick,
  output logic [1:0] active_rate,
  output logic       busy,
  output logic       switch_pending
);

  localparam int HALF0_RAW = CLOCK_FREQUENCY / (2 * RATE0_FREQUENCY);
  localparam int HALF1_RAW = CLOCK_FREQUENCY / (2 * RATE1_FREQUENCY);
  localparam int HALF2_RAW = CLOCK_FREQUENCY / (2 * RATE2_FREQUENCY);
  localparam int HALF3_RAW = CLOCK_FREQUENCY / (2 * RATE3_FREQUENCY);
  localparam int HALF0 = (HALF0_RAW < 1) ? 1 : HALF0_RAW;
  localparam int HALF1 = (HALF1_RAW < 1) ? 1 : HALF1_RAW;
  localparam int HALF2 = (HALF2_RAW < 1) ? 1 : HALF2_RAW;
  localparam int HALF3 = (HALF3_RAW < 1) ? 1 : HALF3_RAW;
  localparam logic [1:0] DEF_RATE = 2'(DEFAULT_RATE);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH, DRAIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] half_m1;
  logic [1:0]           pending;
  logic [1:0]           eff_rate;
  logic                 wrap;
  logic                 boundary;
  logic                 take_req;

  always_comb begin
    case (active_rate)
      2'd0:    half_m1 = CNT_WIDTH'(HALF0 - 1);
      2'd1:    half_m1 = CNT_WIDTH'(HALF1 - 1);
      2'd2:    half_m1 = CNT_WIDTH'(HALF2 - 1);
      default: half_m1 = CNT_WIDTH'(HALF3 - 1);
    endcase
  end

  assign wrap     = (counter == half_m1);
  assign boundary = wrap && divided_clk;
  // Rate that will be in effect after the current boundary.
  assign eff_rate = switch_pending ? pending : active_rate;
  // Once a request is held, any later load overwrites it (last request wins).
  assign take_req = rate_load && ((rate_sel != active_rate) || switch_pending);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      counter        <= '0;
      divided_clk    <= 1'b0;
      tick           <= 1'b0;
      active_rate    <= DEF_RATE;
      pending        <= '0;
      switch_pending <= 1'b0;
      busy           <= 1'b0;
    end else if (state == IDLE) begin
      counter     <= '0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
      if (rate_load) active_rate <= rate_sel;
      if (enable) begin
        state <= RUN;
        busy  <= 1'b1;
      end
    end else begin
      if (wrap) begin
        counter     <= '0;
        divided_clk <= ~divided_clk;
        tick        <= ~divided_clk;
      end else begin
        counter <= counter + CNT_WIDTH'(1);
        tick    <= 1'b0;
      end

      if (boundary) begin
        active_rate <= eff_rate;
        if (!enable) begin
          // Stopping: a load on this edge has no later boundary, so it lands directly.
          state          <= IDLE;
          busy           <= 1'b0;
          switch_pending <= 1'b0;
          if (rate_load) active_rate <= rate_sel;
        end else if (rate_load && (rate_sel != eff_rate)) begin
          pending        <= rate_sel;
          switch_pending <= 1'b1;
          state          <= SWITCH;
        end else begin
          switch_pending <= 1'b0;
          state          <= RUN;
        end
      end else begin
        if (take_req) begin
          pending        <= rate_sel;
          switch_pending <= 1'b1;
        end
        if (!enable)                         state <= DRAIN;
        else if (take_req || switch_pending) state <= SWITCH;
        else                                 state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_clock_rate_controller.sv
// Bench for clock_rate_controller: directed scenarios plus random control traffic,
// checked against a period-position model (HALF = 5/10/20/50 at 1000 Hz input).
module tb_clock_rate_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_load = 1'b0;
  logic       divided_clk;
  logic       tick;
  logic [1:0] active_rate;
  logic       busy;
  logic       switch_pending;

  int checks = 0;
  int errors = 0;

  clock_rate_controller #(
    .CLOCK_FREQUENCY(1000),
    .RATE0_FREQUENCY(100),
    .RATE1_FREQUENCY(50),
    .RATE2_FREQUENCY(25),
    .RATE3_FREQUENCY(10),
    .DEFAULT_RATE(0),
    .CNT_WIDTH(26)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .rate_sel(rate_sel),
    .rate_load(rate_load),
    .divided_clk(divided_clk),
    .tick(tick),
    .active_rate(active_rate),
    .busy(busy),
    .switch_pending(switch_pending)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input int r);
    int hz;
    case (r)
      0:       hz = 100;
      1:       hz = 50;
      2:       hz = 25;
      default: hz = 10;
    endcase
    return 1000 / (2 * hz);
  endfunction

  // Model: position within a low-then-high period; stop and rate requests act at period end.
  bit m_busy = 1'b0;
  int m_pos = 0;
  int m_active = 0;
  bit m_pv = 1'b0;
  int m_pend = 0;
  int m_next;
  assign m_next = m_pv ? m_pend : m_active;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy   <= 1'b0;
      m_pos    <= 0;
      m_active <= 0;
      m_pv     <= 1'b0;
      m_pend   <= 0;
    end else if (!m_busy) begin
      if (rate_load) m_active <= int'(rate_sel);
      if (enable) begin
        m_busy <= 1'b1;
        m_pos  <= 0;
      end
    end else if (m_pos + 1 == 2 * half_of(m_active)) begin
      m_pos    <= 0;
      m_pv     <= 1'b0;
      m_active <= m_next;
      if (!enable) begin
        m_busy <= 1'b0;
        if (rate_load) m_active <= int'(rate_sel);
      end else if (rate_load && (int'(rate_sel) != m_next)) begin
        m_pv   <= 1'b1;
        m_pend <= int'(rate_sel);
      end
    end else begin
      m_pos <= m_pos + 1;
      if (rate_load && ((int'(rate_sel) != m_active) || m_pv)) begin
        m_pv   <= 1'b1;
        m_pend <= int'(rate_sel);
      end
    end
  end

  logic [5:0] dut_v;
  logic [5:0] exp_v;
  assign dut_v = {divided_clk, tick, busy, switch_pending, active_rate};
  assign exp_v = {m_busy && (m_pos >= half_of(m_active)),
                  m_busy && (m_pos == half_of(m_active)),
                  m_busy, m_pv, 2'(m_active)};

  task automatic wait_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (tick) ok = 1'b1;
    end
  endtask

  task automatic wait_rate(input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (int'(active_rate) == r) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; rate_sel = 2'd0; rate_load = 1'b0;
    #12;
    checks++;
    if (dut_v !== 6'b000000) begin
      errors++; $display("FAIL reset_state got=%b want=000000", dut_v);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_tick();
    int first = -1;
    int last = -1;
    int hi = 0;
    int nt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL first_tick_cycle%0d dut=%b model=%b", k, dut_v, exp_v);
      end
      if (divided_clk) hi++;
      if (tick) begin
        if (first < 0) first = k;
        else begin
          checks++;
          if (k - last != 10) begin
            errors++; $display("FAIL tick_spacing got=%0d want=10", k - last);
          end
        end
        last = k;
        nt++;
      end
    end
    checks++;
    if (first != 6) begin errors++; $display("FAIL first_tick_at got=%0d want=6", first); end
    checks++;
    if (hi != 30 || nt != 6) begin
      errors++; $display("FAIL duty_count high=%0d ticks=%0d want 30/6", hi, nt);
    end
  endtask

  task automatic test_switch();
    bit ok;
    bit prev;
    int first = -1;
    int second = -1;
    wait_tick(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL switch_wait_tick timeout"); end
    repeat (2) @(negedge clk);
    rate_sel = 2'd2; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    checks++;
    if (switch_pending !== 1'b1 || active_rate !== 2'd0) begin
      errors++; $display("FAIL switch_capture pend=%b rate=%0d want 1/0", switch_pending, active_rate);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      prev = divided_clk;
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL switch_cycle dut=%b model=%b", dut_v, exp_v);
      end
      if (prev && !divided_clk) ok = 1'b1;
    end
    checks++;
    if (!ok || active_rate !== 2'd2 || switch_pending !== 1'b0) begin
      errors++; $display("FAIL switch_apply seen=%b rate=%0d pend=%b want 1/2/0", ok, active_rate, switch_pending);
    end
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL switch_post_cycle%0d dut=%b model=%b", i, dut_v, exp_v);
      end
      if (tick) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks++;
    if (first != 20 || second != 60) begin
      errors++; $display("FAIL switch_period ticks=%0d,%0d want 20,60", first, second);
    end
  endtask

  task automatic test_last_wins();
    bit ok;
    bit prev;
    int first = -1;
    int second = -1;
    int saw1 = 0;
    wait_tick(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL last_wins_wait_tick timeout"); end
    rate_sel = 2'd1; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    @(negedge clk);
    rate_sel = 2'd3; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    checks++;
    if (switch_pending !== 1'b1 || active_rate !== 2'd2) begin
      errors++; $display("FAIL last_wins_hold pend=%b rate=%0d want 1/2", switch_pending, active_rate);
    end
    ok = 1'b0;
    for (int i = 0; i < 25 && !ok; i++) begin
      prev = divided_clk;
      @(negedge clk);
      if (active_rate === 2'd1) saw1++;
      if (prev && !divided_clk) ok = 1'b1;
    end
    checks++;
    if (!ok || active_rate !== 2'd3) begin
      errors++; $display("FAIL last_wins_apply seen=%b rate=%0d want 1/3", ok, active_rate);
    end
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL last_wins_cycle%0d dut=%b model=%b", i, dut_v, exp_v);
      end
      if (active_rate === 2'd1) saw1++;
      if (tick) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks++;
    if (first != 50 || second != 150 || saw1 != 0) begin
      errors++; $display("FAIL last_wins_period ticks=%0d,%0d rate1_cycles=%0d want 50,150,0", first, second, saw1);
    end
  endtask

  task automatic test_drain();
    bit ok;
    int idle_at = -1;
    int hi = 0;
    int nt = 0;
    rate_sel = 2'd1; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    wait_rate(1, 120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drain_wait_rate timeout"); end
    wait_tick(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drain_wait_tick timeout"); end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    for (int t = 3; t <= 30 && idle_at < 0; t++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL drain_cycle%0d dut=%b model=%b", t, dut_v, exp_v);
      end
      if (!busy) idle_at = t;
      else if (!divided_clk) hi++;
    end
    checks++;
    if (idle_at != 10 || hi != 0) begin
      errors++; $display("FAIL drain_end idle_at=%0d low_while_busy=%0d want 10/0", idle_at, hi);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick || divided_clk || busy) nt++;
    end
    checks++;
    if (nt != 0) begin errors++; $display("FAIL drain_idle_quiet active_cycles=%0d want 0", nt); end
  endtask

  task automatic test_restore();
    bit ok;
    int nb = 0;
    int nt = 0;
    int bad = 0;
    rate_sel = 2'd3; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    checks++;
    if (active_rate !== 2'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_load rate=%0d busy=%b want 3/0", active_rate, busy);
    end
    rate_sel = 2'd0; rate_load = 1'b1; enable = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    checks++;
    if (active_rate !== 2'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL idle_start rate=%0d busy=%b want 0/1", active_rate, busy);
    end
    wait_tick(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restore_wait_tick timeout"); end
    enable = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 2) enable = 1'b1;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL restore_cycle%0d dut=%b model=%b", t, dut_v, exp_v);
      end
      if (!busy) nb++;
      if (tick) begin
        nt++;
        if (t % 10 != 0) bad++;
      end
    end
    checks++;
    if (nb != 0 || nt != 4 || bad != 0) begin
      errors++; $display("FAIL restore_continuity idle=%0d ticks=%0d offbeat=%0d want 0/4/0", nb, nt, bad);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rate_sel = 2'd3; rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    wait_rate(3, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_wait_rate timeout"); end
    wait_tick(60, ok);
    repeat (7) @(negedge clk);
    checks++;
    if (!ok || divided_clk !== 1'b1) begin
      errors++; $display("FAIL reset_mid_setup tick_seen=%b clk_out=%b want 1/1", ok, divided_clk);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== 6'b000000) begin
      errors++; $display("FAIL reset_mid_async got=%b want=000000", dut_v);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_v !== 6'b000000) begin
      errors++; $display("FAIL reset_mid_held got=%b want=000000", dut_v);
    end
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random_cycle%0d dut=%b model=%b", i, dut_v, exp_v);
      end
      if ($urandom_range(39) == 0) enable = ~enable;
      rate_load = ($urandom_range(11) == 0);
      rate_sel  = 2'($urandom_range(3));
    end
    rate_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_switch();
    test_last_wins();
    test_drain();
    test_restore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
